// File: rtl/dsa_cmd_sequencer.sv
// DSA slot command sequencer: pops xocc commands, steps the AXI master engine
// through per-chunk read/write transfers and pushes one response word per command.
//
// state    | meaning
// IDLE     | waiting for a queued command
// FETCH    | pop pulse to the command FIFO
// DECODE   | command word valid; latch fields, classify opcode
// RD_ISSUE | init_read pulse for the current chunk
// RD_WAIT  | waiting for rx_done / error / timeout
// WR_ISSUE | init_write pulse for the current chunk (COPY only)
// WR_WAIT  | waiting for tx_done / error / timeout
// NEXT     | chunk done: bump count and addresses
// RSP      | push response once the response FIFO has room
module dsa_cmd_sequencer #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DSA0_CMD_WIDTH = 96,
  parameter int DSA0_RSP_WIDTH = 32,
  parameter int CHUNK_BYTES    = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DSA0_CMD_WIDTH-1:0] dsa0_xocc_cmd_in,
  input  logic                      dsa0_cmd_fifo_empty,
  output logic                      dsa0_cmd_fifo_rd_en,
  input  logic                      dsa0_rsp_fifo_full,
  output logic                      dsa0_rsp_fifo_wr_en,
  output logic [DSA0_RSP_WIDTH-1:0] dsa0_xocc_cmd_out,
  output logic [ADDRESS_WIDTH-1:0]  eng_rd_addr,
  output logic [ADDRESS_WIDTH-1:0]  eng_wr_addr,
  output logic                      eng_init_read,
  output logic                      eng_init_write,
  input  logic                      eng_rx_done,
  input  logic                      eng_tx_done,
  input  logic                      eng_error,
  output logic                      busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_RD_ISSUE = 4'd3;
  localparam logic [3:0] S_RD_WAIT  = 4'd4;
  localparam logic [3:0] S_WR_ISSUE = 4'd5;
  localparam logic [3:0] S_WR_WAIT  = 4'd6;
  localparam logic [3:0] S_NEXT     = 4'd7;
  localparam logic [3:0] S_RSP      = 4'd8;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_AXI_ERR = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  localparam logic [7:0] OP_COPY = 8'h01;
  localparam logic [7:0] OP_READ = 8'h02;

  localparam logic [15:0]              TMR_LOAD  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] CHUNK_INC = ADDRESS_WIDTH'(CHUNK_BYTES);

  logic [ADDRESS_WIDTH-1:0] cmd_src, cmd_dst;
  logic [15:0]              cmd_n;
  logic [7:0]               cmd_tag, cmd_op;

  assign cmd_src = dsa0_xocc_cmd_in[ADDRESS_WIDTH-1:0];
  assign cmd_dst = dsa0_xocc_cmd_in[32 +: ADDRESS_WIDTH];
  assign cmd_n   = dsa0_xocc_cmd_in[79:64];
  assign cmd_tag = dsa0_xocc_cmd_in[87:80];
  assign cmd_op  = dsa0_xocc_cmd_in[95:88];

  logic [3:0]                state_q, state_d;
  logic                      is_copy_q, is_copy_d;
  logic [15:0]               n_q, n_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [15:0]               tmr_q, tmr_d;
  logic [7:0]                tag_q, tag_d;
  logic [1:0]                status_q, status_d;
  logic [ADDRESS_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDRESS_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DSA0_RSP_WIDTH-1:0] rsp_q, rsp_d;
  logic                      wr_en_q, wr_en_d;
  logic                      rd_en_q, init_rd_q, init_wr_q, busy_q;

  always_comb begin
    state_d   = state_q;
    is_copy_d = is_copy_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    tag_d     = tag_q;
    status_d  = status_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rsp_d     = rsp_q;
    wr_en_d   = 1'b0;
    case (state_q)
      S_IDLE:   if (!dsa0_cmd_fifo_empty) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        is_copy_d = (cmd_op == OP_COPY);
        n_d       = cmd_n;
        tag_d     = cmd_tag;
        cnt_d     = 16'd0;
        rd_addr_d = cmd_src;
        wr_addr_d = cmd_dst;
        if (cmd_op != OP_COPY && cmd_op != OP_READ) begin
          status_d = ST_ILLEGAL;
          state_d  = S_RSP;
        end else if (cmd_n == 16'd0) begin
          status_d = ST_OK;
          state_d  = S_RSP;
        end else begin
          state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        tmr_d   = TMR_LOAD;
        state_d = S_RD_WAIT;
      end
      // error beats a simultaneous done; done beats the final timer tick
      S_RD_WAIT: begin
        if (eng_error) begin
          status_d = ST_AXI_ERR;
          state_d  = S_RSP;
        end else if (eng_rx_done) begin
          state_d = is_copy_q ? S_WR_ISSUE : S_NEXT;
        end else if (tmr_q == 16'd0) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RSP;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_WR_ISSUE: begin
        tmr_d   = TMR_LOAD;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (eng_error) begin
          status_d = ST_AXI_ERR;
          state_d  = S_RSP;
        end else if (eng_tx_done) begin
          state_d = S_NEXT;
        end else if (tmr_q == 16'd0) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RSP;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_NEXT: begin
        cnt_d     = cnt_q + 16'd1;
        rd_addr_d = rd_addr_q + CHUNK_INC;
        wr_addr_d = wr_addr_q + CHUNK_INC;
        if (cnt_q + 16'd1 == n_q) begin
          status_d = ST_OK;
          state_d  = S_RSP;
        end else begin
          state_d = S_RD_ISSUE;
        end
      end
      S_RSP: begin
        if (!dsa0_rsp_fifo_full) begin
          wr_en_d = 1'b1;
          rsp_d   = DSA0_RSP_WIDTH'({status_q, 6'b0, tag_q, cnt_q});
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // pulse outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      is_copy_q <= 1'b0;
      n_q       <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      tag_q     <= '0;
      status_q  <= ST_OK;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rsp_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      init_rd_q <= 1'b0;
      init_wr_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_copy_q <= is_copy_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      tag_q     <= tag_d;
      status_q  <= status_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rsp_q     <= rsp_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= (state_d == S_FETCH);
      init_rd_q <= (state_d == S_RD_ISSUE);
      init_wr_q <= (state_d == S_WR_ISSUE);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign dsa0_cmd_fifo_rd_en = rd_en_q;
  assign dsa0_rsp_fifo_wr_en = wr_en_q;
  assign dsa0_xocc_cmd_out   = rsp_q;
  assign eng_rd_addr         = rd_addr_q;
  assign eng_wr_addr         = wr_addr_q;
  assign eng_init_read       = init_rd_q;
  assign eng_init_write      = init_wr_q;
  assign busy                = busy_q;

endmodule
